// File: rtl/bus_dma_master.sv
// Memory-to-memory copy engine on the core data bus (req/gnt/rvalid).
// Moves len 32-bit words from src to dst: one read then one write per word, at most one
// transaction outstanding. All outputs are registered.
module bus_dma_master #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] words_done_o,
  output logic             data_req_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_addr_o,
  output logic [31:0]      data_wdata_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  input  logic [31:0]      data_rdata_i
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StFinish
  } state_e;

  state_e           state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic             abort_q;
  logic [LEN_W-1:0] words_next;

  assign words_next = words_done_o + LEN_W'(1);

  // Only whole-word transfers are ever issued.
  assign data_be_o = 4'hF;

  // Copy sequencer: state, address/count/data registers and all registered bus outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      abort_q      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      words_done_o <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      // Abort only takes effect at the next word boundary; remember it until then.
      if (abort_i && busy_o) begin
        abort_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (start_i) begin
            words_done_o <= '0;
            if (len_i != '0) begin
              src_q       <= src_addr_i & 32'hFFFF_FFFC;
              dst_q       <= dst_addr_i & 32'hFFFF_FFFC;
              len_q       <= len_i;
              busy_o      <= 1'b1;
              data_req_o  <= 1'b1;
              data_we_o   <= 1'b0;
              data_addr_o <= src_addr_i & 32'hFFFF_FFFC;
              state_q     <= StRdReq;
            end else begin
              done_o  <= 1'b1;
              state_q <= StFinish;
            end
          end
        end
        StRdReq: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state_q    <= StRdWait;
          end
        end
        StRdWait: begin
          if (data_rvalid_i) begin
            data_wdata_o <= data_rdata_i;
            data_req_o   <= 1'b1;
            data_we_o    <= 1'b1;
            data_addr_o  <= dst_q;
            state_q      <= StWrReq;
          end
        end
        StWrReq: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state_q    <= StWrWait;
          end
        end
        StWrWait: begin
          if (data_rvalid_i) begin
            src_q        <= src_q + 32'd4;
            dst_q        <= dst_q + 32'd4;
            words_done_o <= words_next;
            if (words_next == len_q || abort_q || abort_i) begin
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              data_we_o <= 1'b0;
              state_q   <= StFinish;
            end else begin
              data_req_o  <= 1'b1;
              data_we_o   <= 1'b0;
              data_addr_o <= src_q + 32'd4;
              state_q     <= StRdReq;
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master: a randomized bus responder with a memory, and a
// word-by-word copy reference model over a separate memory image.
module tb_bus_dma_master;
  localparam int unsigned LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [31:0]      src_addr_i;
  logic [31:0]      dst_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic [LEN_W-1:0] words_done_o;
  logic             data_req_o;
  logic             data_we_o;
  logic [3:0]       data_be_o;
  logic [31:0]      data_addr_o;
  logic [31:0]      data_wdata_o;
  logic             data_gnt_i;
  logic             data_rvalid_i;
  logic [31:0]      data_rdata_i;

  bus_dma_master #(.LEN_W(LEN_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .src_addr_i    (src_addr_i),
    .dst_addr_i    (dst_addr_i),
    .len_i         (len_i),
    .abort_i       (abort_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .words_done_o  (words_done_o),
    .data_req_o    (data_req_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus-side memory (written by the DUT) and the reference model's memory image.
  bit [31:0] mem     [bit [31:0]];
  bit [31:0] ref_mem [bit [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Current copy and responder state.
  logic [31:0] cur_src, cur_dst;
  int          cur_len, exp_words, reads_acc, writes_acc, writes_done;
  int          gmode, gwait, rvmax, abort_rd, abort_pct, req_wait, k, done_k;
  bit          aborted, ghost, seen_done, outst, outst_wr, prev_stall;
  logic [31:0] prev_addr, prev_wdata, outst_data;
  logic        prev_we;
  int          outst_wait;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(data_req_o), 32'd0);
    check({tag, "_we"}, 32'(data_we_o), 32'd0);
    check({tag, "_be"}, 32'(data_be_o), 32'hF);
    check({tag, "_addr"}, data_addr_o, 32'd0);
    check({tag, "_wdata"}, data_wdata_o, 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_words"}, 32'(words_done_o), 32'd0);
  endtask

  // Assert reset off the clock edge, check the async values, release on a falling edge.
  task automatic do_reset(input string tag);
    start_i       = 1'b0;
    abort_i       = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs(tag);
    outst      = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // A transfer is accepted at the coming edge: score it against the model.
  task automatic accept();
    logic [31:0] ea, ed;
    if (data_we_o) begin
      if (writes_acc >= exp_words) begin
        check("extra_wr", 32'(data_req_o), 32'd0);
      end else begin
        ea = cur_dst + 32'(4 * writes_acc);
        ed = ref_rd(cur_src + 32'(4 * writes_acc));
        check("wr_addr", data_addr_o, ea);
        check("wr_data", data_wdata_o, ed);
        check("wr_be", 32'(data_be_o), 32'hF);
        ref_mem[ea] = ed;
      end
      mem[data_addr_o] = data_wdata_o;
      writes_acc++;
    end else begin
      if (reads_acc >= exp_words) begin
        check("extra_rd", 32'(data_req_o), 32'd0);
      end else begin
        check("rd_addr", data_addr_o, cur_src + 32'(4 * reads_acc));
      end
      outst_data = mem_rd(data_addr_o);
      reads_acc++;
    end
    outst      = 1'b1;
    outst_wr   = data_we_o;
    outst_wait = (rvmax > 0) ? int'($urandom_range(rvmax)) : 0;
  endtask

  // One cycle: called on a falling edge; observes outputs, drives inputs for the next edge.
  task automatic cyc();
    bit g;
    if (prev_stall) begin
      check("hold_req", 32'(data_req_o), 32'd1);
      check("hold_addr", data_addr_o, prev_addr);
      check("hold_we", 32'(data_we_o), 32'(prev_we));
      check("hold_wdata", data_wdata_o, prev_wdata);
    end
    if (outst) check("one_outstanding", 32'(data_req_o), 32'd0);
    if (done_o && !seen_done) begin
      seen_done = 1'b1;
      done_k    = k;
      check("done_words", 32'(words_done_o), 32'(exp_words));
      check("done_busy", 32'(busy_o), 32'd0);
    end else if (!seen_done) begin
      check("busy", 32'(busy_o), (cur_len != 0) ? 32'd1 : 32'd0);
      check("words_progress", 32'(words_done_o), 32'(writes_done));
    end

    // Abort: the word in flight (completions so far + 1) is the last one written.
    abort_i = 1'b0;
    if (busy_o && !aborted &&
        ((abort_rd >= 0 && outst && !outst_wr && reads_acc == abort_rd) ||
         (abort_pct != 0 && int'($urandom_range(99)) < abort_pct))) begin
      abort_i = 1'b1;
      aborted = 1'b1;
      if (writes_done + 1 < exp_words) exp_words = writes_done + 1;
    end

    data_rvalid_i = 1'b0;
    data_rdata_i  = $urandom;
    if (outst) begin
      if (outst_wait == 0) begin
        data_rvalid_i = 1'b1;
        if (!outst_wr) data_rdata_i = outst_data;
        else writes_done++;
        outst = 1'b0;
      end else begin
        outst_wait--;
      end
    end

    // Starts while busy must be ignored.
    start_i = 1'b0;
    if (ghost && busy_o && $urandom_range(5) == 0) begin
      start_i    = 1'b1;
      src_addr_i = $urandom;
      dst_addr_i = $urandom;
      len_i      = LEN_W'($urandom_range(1, 9));
    end

    prev_stall = 1'b0;
    data_gnt_i = 1'b0;
    if (data_req_o) begin
      if (gmode == 0) g = 1'b1;
      else if (gmode == 1) g = (req_wait >= gwait);
      else g = ($urandom_range(2) != 0);
      data_gnt_i = g;
      if (g) begin
        req_wait = 0;
        accept();
      end else begin
        req_wait++;
        prev_stall = 1'b1;
        prev_addr  = data_addr_o;
        prev_we    = data_we_o;
        prev_wdata = data_wdata_o;
      end
    end else if (gmode == 2) begin
      data_gnt_i = 1'($urandom_range(1));
    end
    @(negedge clk_i);
    k++;
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int gm, input int gw, input int rv, input int ard,
                            input int apct, input bit gh);
    cur_src     = src & 32'hFFFF_FFFC;
    cur_dst     = dst & 32'hFFFF_FFFC;
    cur_len     = len;
    exp_words   = len;
    reads_acc   = 0;
    writes_acc  = 0;
    writes_done = 0;
    gmode       = gm;
    gwait       = gw;
    rvmax       = rv;
    abort_rd    = ard;
    abort_pct   = apct;
    ghost       = gh;
    aborted     = 1'b0;
    seen_done   = 1'b0;
    req_wait    = 0;
    prev_stall  = 1'b0;
    outst       = 1'b0;
    done_k      = -1;
    // An abort while idle must not affect the next copy.
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    abort_i       = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("idle_abort_busy", 32'(busy_o), 32'd0);
    start_i    = 1'b1;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = LEN_W'(len);
    k = 0;
    @(negedge clk_i);
    k = 1;
    start_i    = 1'b0;
    src_addr_i = $urandom;
    dst_addr_i = $urandom;
    len_i      = LEN_W'($urandom);
  endtask

  task automatic finish_copy(input bit check_lat);
    while (!seen_done && k < 3000) cyc();
    check("done_seen", 32'(seen_done), 32'd1);
    if (seen_done) begin
      check("done_one_cycle", 32'(done_o), 32'd0);
      check("rd_count", 32'(reads_acc), 32'(exp_words));
      check("wr_count", 32'(writes_acc), 32'(exp_words));
      check("final_words", 32'(words_done_o), 32'(exp_words));
      // With gnt tied high and rvalid one cycle after acceptance, each word takes 4 cycles;
      // done_o appears on the cycle after the last word's final edge.
      if (check_lat) check("latency", 32'(done_k), 32'(4 * cur_len + 1));
    end else begin
      do_reset("recover");
    end
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int gm, input int gw, input int rv, input int ard,
                          input int apct, input bit gh, input bit check_lat);
    start_copy(src, dst, len, gm, gw, rv, ard, apct, gh);
    finish_copy(check_lat);
  endtask

  initial begin
    logic [31:0] rs, rd;
    int          rl;
    rst_i         = 1'b0;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    src_addr_i    = '0;
    dst_addr_i    = '0;
    len_i         = '0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    outst         = 1'b0;
    prev_stall    = 1'b0;
    do_reset("reset");

    // Three-word copy, zero wait states.
    for (int i = 0; i < 3; i++) begin
      mem[32'h100 + 32'(4 * i)]     = 32'hA0 + 32'(i);
      ref_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    end
    run_copy(32'h100, 32'h4000, 3, 0, 0, 0, -1, 0, 1'b0, 1'b1);
    check("t1_w0", mem_rd(32'h4000), 32'hA0);
    check("t1_w1", mem_rd(32'h4004), 32'hA1);
    check("t1_w2", mem_rd(32'h4008), 32'hA2);

    // Same copy with three grant wait states per request.
    for (int i = 0; i < 3; i++) begin
      mem[32'h4000 + 32'(4 * i)]     = 32'h0;
      ref_mem[32'h4000 + 32'(4 * i)] = 32'h0;
    end
    run_copy(32'h100, 32'h4000, 3, 1, 3, 0, -1, 0, 1'b0, 1'b0);
    check("t2_w0", mem_rd(32'h4000), 32'hA0);
    check("t2_w2", mem_rd(32'h4008), 32'hA2);

    // Zero length: no bus activity, immediate done.
    run_copy(32'h200, 32'h300, 0, 0, 0, 0, -1, 0, 1'b0, 1'b1);

    // Source address wrap and unaligned address inputs.
    run_copy(32'hFFFF_FFFC, 32'h800, 2, 0, 0, 0, -1, 0, 1'b0, 1'b1);
    check("wrap_w1", mem_rd(32'h804), init_val(32'h0));
    run_copy(32'h103, 32'h902, 1, 0, 0, 0, -1, 0, 1'b0, 1'b1);
    check("unaligned", mem_rd(32'h900), 32'hA0);

    // Abort during the second word's read wait of a five-word copy.
    run_copy(32'hA00, 32'hB00, 5, 0, 0, 0, 2, 0, 1'b0, 1'b0);
    check("abort_words", 32'(words_done_o), 32'd2);
    check("abort_no_w2", 32'(mem.exists(32'hB08)), 32'd0);

    // Reset while a write request is pending, then a clean copy.
    start_copy(32'h600, 32'h700, 4, 0, 0, 0, -1, 0, 1'b0);
    while (!(data_req_o && data_we_o) && k < 50) cyc();
    check("reached_wr_req", 32'(data_req_o && data_we_o), 32'd1);
    do_reset("mid_reset");
    run_copy(32'h600, 32'h700, 4, 0, 0, 0, -1, 0, 1'b0, 1'b1);

    // Randomized copies: random waits, response delays, aborts and ignored starts.
    for (int n = 0; n < 30; n++) begin
      rs = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                    : 32'h1000 + 32'($urandom_range(255));
      rd = 32'h1000 + 32'($urandom_range(255));
      rl = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 6));
      run_copy(rs, rd, rl, 2, 0, 2, -1, (n % 3 == 0) ? 6 : 0, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
